// File: rtl/stopwatch_pkg.sv
// Shared state encoding, mode constants and prescaler sizing helper for the
// stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } sw_state_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Bits needed to hold a count of 0..div-1, never narrower than one bit.
  function automatic int div_width(input int div);
    int w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stopwatch_controller_tick_prescaler.sv
// Divides clk down to the counter-chain advance rate; counts 0..DIV-1 only
// while run is high and holds its value otherwise.
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic tick
);
  import stopwatch_pkg::*;

  localparam int            CW   = div_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == LAST);

  // restart has priority so a fresh run always begins a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (restart) begin
      r_count <= '0;
    end else if (run) begin
      if (w_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign tick = run & w_last;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM driving an external BCD counter chain. The optional
// lap-hold display freeze is enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_controller #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start_stop,
  input  logic btn_clear,
  input  logic btn_lap,
  input  logic mode_down,
  input  logic chain_terminal,
  output logic cnt_enable,
  output logic cnt_up_down,
  output logic cnt_clear,
  output logic running,
  output logic expired,
  output logic display_hold
);
  import stopwatch_pkg::*;

  // DIV must be at least 2 for the tick to be a single-cycle pulse.
  localparam int DIV = CLK_HZ / TICK_HZ;

  sw_state_t r_state;
  sw_state_t w_state_next;

  logic r_mode;
  logic r_mode_chg;
  logic r_cnt_enable;
  logic r_cnt_up_down;
  logic r_cnt_clear;
  logic r_running;
  logic r_expired;

  logic w_tick;
  logic w_run;
  logic w_restart;
  logic w_clear_evt;
  logic w_mode_change;
  logic w_advance;

  assign w_run     = (r_state == ST_RUN);
  assign w_restart = (r_state == ST_IDLE) && (w_state_next == ST_RUN);

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (w_run),
    .restart(w_restart),
    .tick   (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    w_clear_evt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (btn_clear) begin
          w_clear_evt = 1'b1;
        end
        if (btn_start_stop) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (btn_start_stop) begin
          w_state_next = ST_PAUSE;
        end else if (w_tick && chain_terminal) begin
          w_state_next = ST_EXPIRED;
        end
      end
      ST_PAUSE: begin
        // Clear beats a simultaneous start/stop.
        if (btn_clear) begin
          w_state_next = ST_IDLE;
          w_clear_evt  = 1'b1;
        end else if (btn_start_stop) begin
          w_state_next = ST_RUN;
        end
      end
      ST_EXPIRED: begin
        if (btn_clear) begin
          w_state_next = ST_IDLE;
          w_clear_evt  = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // A start/stop landing on a tick pauses and swallows that advance; a
  // terminal chain turns the tick into expiry instead of a wrap.
  assign w_advance     = w_run && w_tick && !chain_terminal && !btn_start_stop;
  assign w_mode_change = (r_state == ST_IDLE) && (mode_down != r_mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_mode        <= MODE_UP;
      r_mode_chg    <= 1'b0;
      r_cnt_enable  <= 1'b0;
      r_cnt_up_down <= 1'b1;
      r_cnt_clear   <= 1'b1;
      r_running     <= 1'b0;
      r_expired     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt_enable <= w_advance;
      r_running    <= (w_state_next == ST_RUN);
      r_expired    <= (w_state_next == ST_EXPIRED);
      // Mode tracks the switch only in IDLE; direction follows immediately
      // and the counters are reloaded one cycle later in the new direction.
      if (r_state == ST_IDLE) begin
        r_mode        <= mode_down ? MODE_DOWN : MODE_UP;
        r_cnt_up_down <= (mode_down == MODE_UP);
      end
      r_mode_chg  <= w_mode_change;
      r_cnt_clear <= w_clear_evt | r_mode_chg;
    end
  end

  assign cnt_enable  = r_cnt_enable;
  assign cnt_up_down = r_cnt_up_down;
  assign cnt_clear   = r_cnt_clear;
  assign running     = r_running;
  assign expired     = r_expired;

`ifdef STOPWATCH_LAP_HOLD_EN
  logic r_display_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_display_hold <= 1'b0;
    end else if (w_state_next == ST_IDLE) begin
      r_display_hold <= 1'b0;
    end else if (btn_lap && (r_state == ST_RUN || r_state == ST_PAUSE)) begin
      r_display_hold <= ~r_display_hold;
    end
  end

  assign display_hold = r_display_hold;
`else
  logic w_unused_lap;

  assign w_unused_lap = btn_lap;
  assign display_hold = 1'b0;
`endif

endmodule
